rs_ram8_port_arbiter: RTL and testbench
=======================================

Name: rs_ram8_port_arbiter

Overview:
- Two-requester access arbiter and sequencer sitting directly upstream of the single-port RS_RAM8 cell.
- Serialises read and write requests onto the RAM's ADDR/DI/WE inputs.
- Tracks in-flight reads and returns DO to the requester that issued each one.
- Lets two 8-bit datapaths, such as a fetch unit and a load/store unit, share one redstone RAM8 without external glue.

Parameters:
- RD_LATENCY, 1: cycles from RAM_ADDR being driven to RAM_DO being valid at the sampling edge; legal range 1..4.
- RR, 1: 1 selects round-robin arbitration; 0 selects fixed priority with r0 highest.

Ports:
- CLK  input  1  rising-edge clock, shared with RS_RAM8.CLK
- RST_N  input  1  synchronous active-low reset
- REQ0  input  1  requester 0 request; held with WE0/ADDR0/WDATA0 stable until GNT0
- WE0  input  1  requester 0: 1 = write, 0 = read
- ADDR0  input  8  requester 0 address
- WDATA0  input  8  requester 0 write data
- GNT0  output  1  one-cycle grant pulse to requester 0
- RVALID0  output  1  one-cycle read-data-valid pulse to requester 0
- RDATA0  output  8  read data for requester 0
- REQ1, WE1, ADDR1, WDATA1, GNT1, RVALID1, RDATA1: identical to the requester 0 ports, for requester 1
- RAM_ADDR  output  8  drives RS_RAM8.ADDR
- RAM_DI  output  8  drives RS_RAM8.DI
- RAM_WE  output  1  drives RS_RAM8.WE
- RAM_DO  input  8  from RS_RAM8.DO

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-low: applied at any rising edge where RST_N = 0.
- Reset values: GNT0/1 = 0, RVALID0/1 = 0, RDATA0/1 = 0x00, RAM_WE = 0, RAM_ADDR = 0x00, RAM_DI = 0x00, LAST = 1.
  - With LAST = 1, r0 wins the first tie.
  - Reset clears the in-flight owner pipeline.
- Eligibility: requester i is eligible at edge k if REQi = 1 and GNTi = 0 during cycle k.
  - A granted requester is therefore never re-sampled while its GNT is high.
  - Any one requester issues at most once every 2 cycles.
  - Two alternating requesters together give 1 access per cycle.
- Arbitration at edge k:
  - Only one eligible: that requester wins.
  - Both eligible, RR = 1: the winner is the requester that is not LAST.
  - Both eligible, RR = 0: r0 wins.
  - LAST updates to the winner on every grant.
- Issue, registered at edge k:
  - GNTw = 1 for exactly one cycle.
  - RAM_ADDR = ADDRw, RAM_WE = WEw.
  - RAM_DI = WDATAw on a write; RAM_DI holds its previous value on a read.
- No winner at edge k:
  - GNT0 = GNT1 = 0, RAM_WE = 0.
  - RAM_ADDR and RAM_DI hold their previous values (no toggling of the redstone bus).
- Write completion: RAM_WE is high for exactly one cycle per write. A write produces no RVALID.
- Read return: each read pushes a tag {valid, owner} into an RD_LATENCY-deep shift pipeline.
  - At edge k + RD_LATENCY, if the tag is valid, RAM_DO is captured into RDATAowner and RVALIDowner = 1 for one cycle.
  - RDATA holds its value between pulses.
  - The other requester's RVALID stays 0.
- Pipelining: reads may issue every cycle. Returns stay in issue order, and each is tagged with the correct owner.
- Read-after-write to the same address: the read, issued at least 1 cycle after the write's RAM_WE cycle, returns the new data. RS_RAM8 updates at the write edge.
- REQ deasserted before GNT: the request is withdrawn with no side effects. Changing ADDR/WE/WDATA while REQ = 1 and GNT = 0 is legal; the values sampled at the grant edge apply.
- Reset mid-operation: in-flight reads are discarded and no RVALID is produced for them. The first grant after release is at the first edge with RST_N = 1.

Test Plan:
- Reset: RST_N = 0 for 3 cycles with REQ0 = 1 → all outputs 0 throughout and no GNT. First edge with RST_N = 1 → GNT0 = 1 the following cycle.
- Write then read (RD_LATENCY = 1): r0 writes ADDR 0x12 / WDATA 0xA5 → GNT0 plus one cycle of RAM_WE = 1, RAM_ADDR = 0x12, RAM_DI = 0xA5. r0 then reads 0x12 → RVALID0 = 1 with RDATA0 = 0xA5 one cycle after GNT0; RVALID1 stays 0.
- Round-robin contention (RR = 1): both requesters hold reads continuously, r0 at 0x01 and r1 at 0x02 → GNT sequence 0,1,0,1,...; RAM_ADDR 01,02,01,02; RVALID alternates with the matching data.
- Fixed priority (RR = 0): r0 and r1 both request from the same edge → r0 is granted first, r1 in the next cycle (r0 ineligible), then r0 again. Drop REQ0 → r1 is granted every other cycle.
- Latency pipeline (RD_LATENCY = 3): RAM preloaded 0x10 = 0x11, 0x20 = 0x22. Reads of 0x10 (r0) and 0x20 (r1) issue back-to-back → RVALID0/RDATA0 = 0x11 three cycles after GNT0, then RVALID1/RDATA1 = 0x22 one cycle later.
- Reset mid-flight (RD_LATENCY = 2): grant a read, then RST_N = 0 at the next edge → no RVALID pulses, all outputs 0, LAST = 1.

Source files
------------

// File: rtl/rs_ram8_port_arbiter.sv
// rtl/rs_ram8_port_arbiter.sv - two-requester arbiter and read-return sequencer for RS_RAM8
// A granted requester sits out one cycle, so alternating requesters fill every RAM slot.
module rs_ram8_port_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter bit RR         = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req0_i,
  input  logic       we0_i,
  input  logic [7:0] addr0_i,
  input  logic [7:0] wdata0_i,
  output logic       gnt0_o,
  output logic       rvalid0_o,
  output logic [7:0] rdata0_o,
  input  logic       req1_i,
  input  logic       we1_i,
  input  logic [7:0] addr1_i,
  input  logic [7:0] wdata1_i,
  output logic       gnt1_o,
  output logic       rvalid1_o,
  output logic [7:0] rdata1_o,
  output logic [7:0] ram_addr_o,
  output logic [7:0] ram_di_o,
  output logic       ram_we_o,
  input  logic [7:0] ram_do_i
);

  logic                  gnt0_q, gnt1_q, gnt0_d, gnt1_d;
  logic                  rvalid0_q, rvalid1_q;
  logic [7:0]            rdata0_q, rdata1_q;
  logic [7:0]            ram_addr_q, ram_addr_d, ram_di_q, ram_di_d;
  logic                  ram_we_q, ram_we_d;
  logic                  last_q, last_d;
  logic [RD_LATENCY-1:0] tag_v_q, tag_own_q;

  logic       elig0, elig1, win_valid, win1, win_we, issue_rd;
  logic [7:0] win_addr, win_wdata;
  logic       ret_v, ret_own;

  always_comb begin
    elig0     = req0_i & ~gnt0_q;
    elig1     = req1_i & ~gnt1_q;
    win_valid = elig0 | elig1;
    // last_q names the previous winner; on a tie under round-robin the other side wins
    win1      = elig1 & (~elig0 | (RR & ~last_q));
    win_we    = win1 ? we1_i : we0_i;
    win_addr  = win1 ? addr1_i : addr0_i;
    win_wdata = win1 ? wdata1_i : wdata0_i;
    issue_rd  = win_valid & ~win_we;

    gnt0_d     = win_valid & ~win1;
    gnt1_d     = win_valid & win1;
    ram_we_d   = win_valid & win_we;
    ram_addr_d = win_valid ? win_addr : ram_addr_q;
    ram_di_d   = (win_valid && win_we) ? win_wdata : ram_di_q;
    last_d     = win_valid ? win1 : last_q;

    ret_v   = tag_v_q[RD_LATENCY-1];
    ret_own = tag_own_q[RD_LATENCY-1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= 8'h00;
      rdata1_q   <= 8'h00;
      ram_addr_q <= 8'h00;
      ram_di_q   <= 8'h00;
      ram_we_q   <= 1'b0;
      last_q     <= 1'b1;
      tag_v_q    <= '0;
      tag_own_q  <= '0;
    end else begin
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      ram_addr_q <= ram_addr_d;
      ram_di_q   <= ram_di_d;
      ram_we_q   <= ram_we_d;
      last_q     <= last_d;

      // Tag pipeline: stage RD_LATENCY-1 lines up with RAM data valid at this edge
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_own_q[i] <= tag_own_q[i-1];
      end
      tag_v_q[0]   <= issue_rd;
      tag_own_q[0] <= win1;

      rvalid0_q <= ret_v & ~ret_own;
      rvalid1_q <= ret_v & ret_own;
      if (ret_v && !ret_own) rdata0_q <= ram_do_i;
      if (ret_v && ret_own)  rdata1_q <= ram_do_i;
    end
  end

  assign gnt0_o     = gnt0_q;
  assign gnt1_o     = gnt1_q;
  assign rvalid0_o  = rvalid0_q;
  assign rvalid1_o  = rvalid1_q;
  assign rdata0_o   = rdata0_q;
  assign rdata1_o   = rdata1_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_di_o   = ram_di_q;
  assign ram_we_o   = ram_we_q;

endmodule

// File: tb/tb_rs_ram8_port_arbiter.sv
// tb/tb_rs_ram8_port_arbiter.sv - bench for rs_ram8_port_arbiter
// Three instances share stimulus: [0] RR=1 lat 1, [1] RR=0 lat 2, [2] RR=1 lat 3.
module tb_rs_ram8_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [7:0] a0, d0, a1, d1;

  logic       gnt0 [3], gnt1 [3], rv0 [3], rv1 [3], rwe [3];
  logic [7:0] rd0 [3], rd1 [3], raddr [3], rdi [3], rdo [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = g + 1;
    localparam bit RRP = (g != 1);

    bit   [7:0] mem [256];
    logic [7:0] dl0, dl1;

    always @(posedge clk) begin
      if (rwe[g]) mem[raddr[g]] <= rdi[g];
      dl0 <= mem[raddr[g]];
      dl1 <= dl0;
    end

    assign rdo[g] = (LAT == 1) ? mem[raddr[g]] : (LAT == 2) ? dl0 : dl1;

    rs_ram8_port_arbiter #(.RD_LATENCY(LAT), .RR(RRP)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req0_i(req0), .we0_i(we0), .addr0_i(a0), .wdata0_i(d0),
      .gnt0_o(gnt0[g]), .rvalid0_o(rv0[g]), .rdata0_o(rd0[g]),
      .req1_i(req1), .we1_i(we1), .addr1_i(a1), .wdata1_i(d1),
      .gnt1_o(gnt1[g]), .rvalid1_o(rv1[g]), .rdata1_o(rd1[g]),
      .ram_addr_o(raddr[g]), .ram_di_o(rdi[g]), .ram_we_o(rwe[g]), .ram_do_i(rdo[g])
    );
  end

  typedef struct {
    logic       req0, we0;
    logic [7:0] a0, d0;
    logic       req1, we1;
    logic [7:0] a1, d1;
    logic       g0, g1, rwe;
    logic [7:0] raddr, rdi;
    logic       v0, v1;
    logic [7:0] rd0, rd1;
  } vec_t;

  vec_t tbl [16];

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [7:0] x0, input logic [7:0] y0,
                       input logic r1, input logic w1, input logic [7:0] x1, input logic [7:0] y1);
    req0 = r0; we0 = w0; a0 = x0; d0 = y0;
    req1 = r1; we1 = w1; a1 = x1; d1 = y1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int g, input string nm);
    chk1({nm, " gnt0"}, gnt0[g], 1'b0);
    chk1({nm, " gnt1"}, gnt1[g], 1'b0);
    chk1({nm, " ram_we"}, rwe[g], 1'b0);
    chk8({nm, " ram_addr"}, raddr[g], 8'h00);
    chk8({nm, " ram_di"}, rdi[g], 8'h00);
    chk1({nm, " rvalid0"}, rv0[g], 1'b0);
    chk1({nm, " rvalid1"}, rv1[g], 1'b0);
    chk8({nm, " rdata0"}, rd0[g], 8'h00);
    chk8({nm, " rdata1"}, rd1[g], 8'h00);
  endtask

  initial begin
    // inputs r0{req,we,addr,wdata} r1{...} | expected g0 g1 we addr di v0 v1 rd0 rd1 on instance 0
    tbl[0]  = '{1'b1,1'b1,8'h12,8'hA5, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,8'h12,8'hA5, 1'b0,1'b0,8'h00,8'h00};
    tbl[1]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h12,8'hA5, 1'b0,1'b0,8'h00,8'h00};
    tbl[2]  = '{1'b1,1'b0,8'h12,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h12,8'hA5, 1'b0,1'b0,8'h00,8'h00};
    tbl[3]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h12,8'hA5, 1'b1,1'b0,8'hA5,8'h00};
    tbl[4]  = '{1'b1,1'b1,8'h01,8'h3C, 1'b1,1'b1,8'h02,8'hC3, 1'b0,1'b1,1'b1,8'h02,8'hC3, 1'b0,1'b0,8'hA5,8'h00};
    tbl[5]  = '{1'b1,1'b1,8'h01,8'h3C, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b1,8'h01,8'h3C, 1'b0,1'b0,8'hA5,8'h00};
    tbl[6]  = '{1'b1,1'b0,8'h01,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b0,1'b1,1'b0,8'h02,8'h3C, 1'b0,1'b0,8'hA5,8'h00};
    tbl[7]  = '{1'b1,1'b0,8'h01,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b1,1'b0,1'b0,8'h01,8'h3C, 1'b0,1'b1,8'hA5,8'hC3};
    tbl[8]  = '{1'b1,1'b0,8'h01,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b0,1'b1,1'b0,8'h02,8'h3C, 1'b1,1'b0,8'h3C,8'hC3};
    tbl[9]  = '{1'b1,1'b0,8'h01,8'h00, 1'b1,1'b0,8'h02,8'h00, 1'b1,1'b0,1'b0,8'h01,8'h3C, 1'b0,1'b1,8'h3C,8'hC3};
    tbl[10] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h01,8'h3C, 1'b1,1'b0,8'h3C,8'hC3};
    tbl[11] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h01,8'h3C, 1'b0,1'b0,8'h3C,8'hC3};
    tbl[12] = '{1'b1,1'b1,8'h01,8'hFF, 1'b1,1'b0,8'h02,8'h00, 1'b0,1'b1,1'b0,8'h02,8'h3C, 1'b0,1'b0,8'h3C,8'hC3};
    tbl[13] = '{1'b0,1'b1,8'h01,8'hFF, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h02,8'h3C, 1'b0,1'b1,8'h3C,8'hC3};
    tbl[14] = '{1'b1,1'b0,8'h01,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,8'h01,8'h3C, 1'b0,1'b0,8'h3C,8'hC3};
    tbl[15] = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,8'h01,8'h3C, 1'b1,1'b0,8'h3C,8'hC3};

    // Reset held three cycles with r0 already requesting
    rst_n = 1'b0;
    drive(tbl[0].req0, tbl[0].we0, tbl[0].a0, tbl[0].d0, tbl[0].req1, tbl[0].we1, tbl[0].a1, tbl[0].d1);
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int g = 0; g < 3; g++) chk_zero(g, $sformatf("reset c%0d i%0d", c, g));
    end
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].req0, tbl[i].we0, tbl[i].a0, tbl[i].d0, tbl[i].req1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
      tick();
      chk1($sformatf("s%0d gnt0", i), gnt0[0], tbl[i].g0);
      chk1($sformatf("s%0d gnt1", i), gnt1[0], tbl[i].g1);
      chk1($sformatf("s%0d ram_we", i), rwe[0], tbl[i].rwe);
      chk8($sformatf("s%0d ram_addr", i), raddr[0], tbl[i].raddr);
      chk8($sformatf("s%0d ram_di", i), rdi[0], tbl[i].rdi);
      chk1($sformatf("s%0d rvalid0", i), rv0[0], tbl[i].v0);
      chk1($sformatf("s%0d rvalid1", i), rv1[0], tbl[i].v1);
      chk8($sformatf("s%0d rdata0", i), rd0[0], tbl[i].rd0);
      chk8($sformatf("s%0d rdata1", i), rd1[0], tbl[i].rd1);
    end

    // Fixed priority on instance 1; instance 0 (last winner r0) must favour r1 on the tie
    idle(); tick(); tick();
    drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
    tick();
    chk1("fp0 gnt0", gnt0[1], 1'b1); chk1("fp0 gnt1", gnt1[1], 1'b0);
    chk8("fp0 ram_addr", raddr[1], 8'h01);
    chk1("rr tie gnt1", gnt1[0], 1'b1);
    tick();
    chk1("fp1 gnt0", gnt0[1], 1'b0); chk1("fp1 gnt1", gnt1[1], 1'b1);
    chk8("fp1 ram_addr", raddr[1], 8'h02);
    tick();
    chk1("fp2 gnt0", gnt0[1], 1'b1); chk1("fp2 gnt1", gnt1[1], 1'b0);
    req0 = 1'b0;
    tick();
    chk1("fp3 gnt0", gnt0[1], 1'b0); chk1("fp3 gnt1", gnt1[1], 1'b1);
    tick();
    chk1("fp4 gnt0", gnt0[1], 1'b0); chk1("fp4 gnt1", gnt1[1], 1'b0);
    tick();
    chk1("fp5 gnt0", gnt0[1], 1'b0); chk1("fp5 gnt1", gnt1[1], 1'b1);
    idle(); repeat (4) tick();

    // Latency 3 on instance 2: preload 0x10=0x11, 0x20=0x22, then back-to-back reads
    drive(1'b1, 1'b1, 8'h10, 8'h11, 1'b1, 1'b1, 8'h20, 8'h22);
    tick(); tick();
    idle(); repeat (4) tick();
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk1("lat x0 gnt0", gnt0[2], 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    chk1("lat x1 gnt1", gnt1[2], 1'b1);
    chk1("lat x1 rvalid0", rv0[2], 1'b0);
    idle();
    tick();
    chk1("lat x2 rvalid0", rv0[2], 1'b0); chk1("lat x2 rvalid1", rv1[2], 1'b0);
    tick();
    chk1("lat x3 rvalid0", rv0[2], 1'b1); chk1("lat x3 rvalid1", rv1[2], 1'b0);
    chk8("lat x3 rdata0", rd0[2], 8'h11);
    tick();
    chk1("lat x4 rvalid0", rv0[2], 1'b0); chk1("lat x4 rvalid1", rv1[2], 1'b1);
    chk8("lat x4 rdata1", rd1[2], 8'h22);
    tick();
    chk1("lat x5 rvalid0", rv0[2], 1'b0); chk1("lat x5 rvalid1", rv1[2], 1'b0);
    repeat (2) tick();

    // Reset one edge after a read grant: no return, all state cleared, LAST back to 1
    drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk1("mid gnt0", gnt0[1], 1'b1);
    chk1("mid rr gnt0", gnt0[0], 1'b1);
    idle();
    rst_n = 1'b0;
    tick();
    chk_zero(1, "mid rst i1");
    chk_zero(0, "mid rst i0");
    rst_n = 1'b1;
    tick();
    chk1("mid r2 rvalid0", rv0[1], 1'b0);
    chk1("mid r2 rvalid1", rv1[1], 1'b0);
    drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
    tick();
    chk1("mid r3 last gnt0", gnt0[0], 1'b1);
    chk1("mid r3 last gnt1", gnt1[0], 1'b0);
    chk1("mid r3 rvalid0", rv0[1], 1'b0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
